// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage feeding an IF/ID register with a valid/ready handshake.
// Optional macro MISALIGN_TRAP_EN: a misaligned redirect traps into a sticky FAULT state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_add,
    input  logic [31:0] inst_code,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_inst,
    output logic        fetch_fault
);

    // Handshake: a transfer happens when if_valid && id_ready; if_* hold while if_valid && !id_ready.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        fault_q, fault_d;
    logic        trap;
    logic [31:0] aligned_target;

    assign aligned_target = redirect_target & ~32'h0000_0003;

`ifdef MISALIGN_TRAP_EN
    assign trap = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_inst_d     = if_inst_q;
        fault_d       = fault_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (trap) begin
                    state_d    = ST_FAULT;
                    if_valid_d = 1'b0;
                    fault_d    = 1'b1;
                end else if (redirect_valid) begin
                    pc_d = aligned_target;
                end
            end
            ST_RUN: begin
                if (trap) begin
                    state_d    = ST_FAULT;
                    if_valid_d = 1'b0;
                    fault_d    = 1'b1;
                end else if (redirect_valid) begin
                    pc_d       = aligned_target;
                    if_valid_d = 1'b0;
                end else if (!if_valid_q || id_ready) begin
                    if_pc_d       = pc_q;
                    if_inst_d     = inst_code;
                    if_pc_plus4_d = pc_q + 32'd4;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_q + 32'd4;
                end
            end
            ST_FAULT: begin
                // Frozen until reset: no captures, redirects ignored.
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0000_0000;
            if_pc_plus4_q <= 32'h0000_0004;
            if_inst_q     <= NOP_INST;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_inst_q     <= if_inst_d;
            fault_q       <= fault_d;
        end
    end

    assign inst_add    = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_inst     = if_inst_q;
    assign fetch_fault = fault_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch stage directly upstream of the integrated instruction memory. Drives inst_add to the memory and samples the combinational inst_code it returns in the same cycle. Registers {pc, instruction} into an IF/ID output register with a valid/ready handshake toward decode. Accepts branch/jump redirects from execute and flushes on them.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction placed in if_inst on reset (ADDI x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
inst_add  output  32  fetch address to instruction memory; equals the PC register
inst_code  input  32  instruction word from memory for the current inst_add, same cycle
redirect_valid  input  1  take redirect_target as next PC and flush this cycle
redirect_target  input  32  redirect address
id_ready  input  1  decode accepts if_* this cycle
if_valid  output  1  if_pc/if_inst hold a valid fetched instruction
if_pc  output  32  address of if_inst
if_pc_plus4  output  32  if_pc + 4, modulo 2^32
if_inst  output  32  fetched instruction
fetch_fault  output  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-redirect or mid-stall): pc=RESET_PC, state=BOOT, if_valid=0, if_pc=0, if_pc_plus4=4, if_inst=NOP_INST, fetch_fault=0.
- inst_add = pc, purely combinational from the PC register.
- States: BOOT, RUN, FAULT.
- BOOT: lasts exactly one cycle after reset deassert; no capture; pc unchanged; next state RUN. A redirect in BOOT is honoured (pc<=target) and the next state is still RUN.
- RUN, priority order per cycle:
  1. redirect_valid=1: pc<=target; if_valid<=0 (flush, even if id_ready=0); no capture this cycle.
  2. else if (if_valid=0 or id_ready=1): capture if_pc<=pc, if_inst<=inst_code, if_pc_plus4<=pc+4, if_valid<=1; pc<=pc+4.
  3. else (if_valid=1, id_ready=0): hold pc and all if_* unchanged.
- Handshake: a transfer occurs when if_valid=1 and id_ready=1. if_* are stable while if_valid=1 and id_ready=0. Back-to-back transfers every cycle when id_ready stays high.
- Latency: the instruction at pc appears on if_* one clock after that pc is on inst_add. First valid instruction at cycle 2 after reset release (BOOT, then capture).
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), no flag.
- Without the feature, redirect_target[1:0] is forced to 2'b00 before loading pc.
- No state other than reset leaves FAULT.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: in BOOT or RUN, redirect_valid=1 with redirect_target[1:0]!=0 loads no PC. State goes to FAULT, if_valid<=0, fetch_fault<=1. In FAULT: pc frozen, no captures, redirects ignored, fetch_fault held at 1 until reset.
- Undefined: FAULT is unreachable. fetch_fault is tied to 0. Target low bits are cleared as in Behaviour.

Test Plan:
- Reset with RESET_PC=0x0: inst_add=0x0, if_valid=0, if_inst=0x00000013. After release with id_ready=1: if_valid rises on cycle 2, and if_pc is 0x0, 0x4, 0x8 on consecutive cycles with if_inst matching memory contents.
- Hold id_ready=0 for 3 cycles while if_pc=0x8: if_pc, if_inst and inst_add=0xC stay constant. On id_ready=1, the next cycle shows if_pc=0xC.
- redirect_valid=1 with target 0x100 while id_ready=0: next cycle if_valid=0 and inst_add=0x100; the cycle after, if_pc=0x100 with if_valid=1.
- Preload pc to 0xFFFF_FFFC via redirect: the next capture shows if_pc_plus4=0x0, and inst_add wraps to 0x0.
- Assert reset asynchronously mid-stream between clock edges: outputs reach reset values immediately, and the BOOT cycle repeats after release.
- Redirect to 0x102. Without MISALIGN_TRAP_EN: inst_add=0x100, fetch_fault=0. With it defined: fetch_fault=1, if_valid=0, inst_add frozen at its pre-redirect value, and a later redirect to 0x200 is ignored.
